// File: rtl/clock_div_ctrl.sv
// Run-time controller for the divided clock path.
// Holds the half-period reload value, runs/stops/one-shots the divided clock,
// and accepts new divide values through a one-deep shadow register that is
// applied only at a terminal count so clk_o never glitches.
module clock_div_ctrl #(
  parameter int          CNT_W       = 22,
  parameter int unsigned DEFAULT_DIV = 1039999
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             tick_o,
  output logic             clk_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  // A zero divide would give a one-cycle half-period; the floor is 1.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] div);
    if (div == '0) begin
      clamp_div = CNT_W'(1);
    end else begin
      clamp_div = div;
    end
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] active_div_q, active_div_d;
  logic             active_os_q, active_os_d;
  logic [CNT_W-1:0] shadow_div_q, shadow_div_d;
  logic             shadow_os_q, shadow_os_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic             tc_s;
  logic             capture_s;
  logic             apply_s;

  assign tc_s      = (state_q != ST_IDLE) && (count_q == active_div_q);
  assign capture_s = cfg_valid && !pend_q;
  // IDLE applies a pending value straight away; running states wait for a TC.
  assign apply_s   = pend_q && ((state_q == ST_IDLE) || tc_s);

  assign cfg_ready = !pend_q;
  assign busy      = (state_q != ST_IDLE);
  assign tick_o    = tick_q;
  assign clk_o     = clk_q;
  assign done_o    = done_q;

  // Next-state, counter and registered-output logic for the divider FSM.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        clk_d   = 1'b0;
        // stop wins over a simultaneous start
        if (start && !stop) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (tc_s) begin
          count_d = '0;
          tick_d  = 1'b1;
          clk_d   = !clk_q;
          if (active_os_q) begin
            // one-shot ends here; IDLE clears clk_o on the following cycle
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (stop) begin
            state_d = ST_STOPPING;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
          if (stop) begin
            state_d = ST_STOPPING;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_STOPPING: begin
        if (tc_s) begin
          count_d = '0;
          tick_d  = 1'b1;
          done_d  = 1'b1;
          clk_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q + CNT_W'(1);
          state_d = ST_STOPPING;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  // Shadow capture and application of pending divide values.
  always_comb begin
    active_div_d = active_div_q;
    active_os_d  = active_os_q;
    shadow_div_d = shadow_div_q;
    shadow_os_d  = shadow_os_q;
    pend_d       = pend_q;

    if (apply_s) begin
      active_div_d = shadow_div_q;
      active_os_d  = shadow_os_q;
      pend_d       = 1'b0;
    end else begin
      active_div_d = active_div_q;
      active_os_d  = active_os_q;
    end

    // capture_s requires pend_q=0 and apply_s requires pend_q=1, so they never collide
    if (capture_s) begin
      shadow_div_d = clamp_div(cfg_div);
      shadow_os_d  = cfg_oneshot;
      pend_d       = 1'b1;
    end else begin
      shadow_div_d = shadow_div_q;
      shadow_os_d  = shadow_os_q;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      active_div_q <= DEF_DIV_C;
      active_os_q  <= 1'b0;
      shadow_div_q <= DEF_DIV_C;
      shadow_os_q  <= 1'b0;
      pend_q       <= 1'b0;
      clk_q        <= 1'b0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      active_div_q <= active_div_d;
      active_os_q  <= active_os_d;
      shadow_div_q <= shadow_div_d;
      shadow_os_q  <= shadow_os_d;
      pend_q       <= pend_d;
      clk_q        <= clk_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
Run-time controller for the board's clock divider path on the internal oscillator clock domain.
- Owns the half-period reload value; starts, stops and one-shots the divided output.
- Accepts new divide values over a valid/ready handshake and applies them glitch-free at a terminal count.
- Sits between the state-machine logic, which requests rates and ticks, and every consumer of the slow clock/tick.

Parameters:
- CNT_W, 22, width of the divide counter and of cfg_div.
- DEFAULT_DIV, 1039999, reload value after reset; must fit in CNT_W bits. At 2.08 MHz this gives a 1 Hz clk_o.

Ports:
- clk_i  input  1  oscillator clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  new divide value offered.
- cfg_ready  output  1  shadow register empty; the offer is accepted this cycle when cfg_valid=1.
- cfg_div  input  CNT_W  half-period terminal count.
- cfg_oneshot  input  1  mode captured with cfg_div: 1 = one-shot, 0 = continuous.
- start  input  1  single-cycle start request.
- stop  input  1  single-cycle stop request.
- busy  output  1  state is not IDLE.
- tick_o  output  1  one-cycle pulse at each terminal count.
- clk_o  output  1  divided clock; toggles at each terminal count.
- done_o  output  1  one-cycle pulse when a one-shot completes or a stop completes.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State = IDLE; count=0; active_div=DEFAULT_DIV; active_oneshot=0; pend=0.
  - Outputs: cfg_ready=1, clk_o=0, tick_o=0, done_o=0, busy=0.
  - Reset asserted mid-operation aborts immediately to these values. No done_o pulse.
- Terminal count (TC): count==active_div while in RUN or STOPPING.
  - On TC: count<=0, tick_o=1 for that one cycle, clk_o toggles.
  - Otherwise count<=count+1.
  - Half-period = active_div+1 cycles; full clk_o period = 2*(active_div+1) cycles.
- Config handshake:
  - cfg_ready = !pend.
  - cfg_valid && cfg_ready loads the shadow registers and sets pend=1.
  - cfg_div=0 is clamped to 1 on capture, so the minimum half-period is 2 cycles.
  - Holding cfg_valid while cfg_ready=0 has no effect.
- Applying a pending value:
  - In IDLE: active_div/active_oneshot <= shadow and pend<=0 on the cycle after capture.
  - In RUN/STOPPING: applied on a TC cycle. The new value governs the next half-period; count restarts at 0.
  - Capture on the same cycle as a TC: the value goes to the shadow and is applied at the following TC, not the current one.
- State IDLE:
  - count held at 0, clk_o=0.
  - start=1 -> RUN with count=0.
  - start and stop together -> stop wins; stay IDLE, no done_o.
  - stop alone -> ignored.
- State RUN:
  - Counts as above.
  - TC with active_oneshot=1 -> IDLE. clk_o toggles to 1 on that TC and is cleared on the next cycle. done_o pulses on the TC cycle.
  - stop=1 -> STOPPING.
  - start is ignored.
- State STOPPING:
  - Counts normally.
  - On the next TC: clk_o<=0 (not toggled), tick_o=1, done_o=1, count<=0 -> IDLE.
  - start and stop are ignored.
  - A stop on the same cycle as a TC in RUN is handled normally: the TC toggles, then the state goes to STOPPING.
- Output timing and arithmetic:
  - tick_o and done_o are registered, asserted in the cycle after the TC is detected, and never longer than 1 cycle.
  - All outputs are registered; no combinational path from inputs to outputs except cfg_ready from pend.
  - Arithmetic is unsigned CNT_W bits; count never exceeds active_div, so no wrap.

Test Plan:
1. Reset, cfg_div=3 continuous, start -> first tick_o 4 cycles after start. clk_o toggles every 4 cycles (period 8). busy=1.
2. Running at div=3, offer cfg_div=1 mid-half-period -> cfg_ready drops for 1..4 cycles. The old half-period completes at 4 cycles, then half-periods are 2 cycles. cfg_ready=1 after the applying TC.
3. cfg_div=2 with cfg_oneshot=1, start -> exactly one tick_o after 3 cycles. done_o pulses with it. busy=0 and clk_o=0 the cycle after.
4. Running at div=5 with clk_o=1, pulse stop at count=2 -> STOPPING. At count=5: clk_o=0, done_o=1, then IDLE. A further start restarts cleanly from count=0.
5. cfg_div=0 -> clamped to 1; half-period is 2 cycles. start and stop in the same cycle while IDLE -> stays IDLE, no done_o.
6. Assert reset_n=0 mid-RUN asynchronously (between clock edges) -> clk_o=0, busy=0 and cfg_ready=1 immediately. active_div returns to DEFAULT_DIV, so a subsequent start gives the first tick after 1040000 cycles.
